riscoffee_fetch: RTL

//  Instruction-fetch stage directly downstream of the PC register. Presents the current PC to instruction

---
 rtl/riscoffee_fetch.sv | 138 +++++++++++++
 1 files changed

// File: rtl/riscoffee_fetch.sv
// rtl/riscoffee_fetch.sv - instruction fetch stage with in-order tag FIFO and decode queue
//
// Purpose: presents the PC to instruction memory and tracks requests that are still in flight.
//    Returned words are paired with their PC tags and buffered in order. Words are handed to decode
//    over valid/ready. On a redirect, all buffered and in-flight work is dropped.
// Ports:
//    i_clk, i_rst          clock; asynchronous active-high reset
//    i_fetch_pc            current PC from the PC stage
//    o_pc_advance          PC consumed this cycle; the PC stage steps
//    i_flush               redirect: discard everything buffered and in flight
//    o_imem_req_*          fetch request valid/ready and word-aligned address
//    i_imem_resp_*         in-order response valid and data
//    o_instr_valid/i_instr_ready, o_instr, o_instr_pc   decode-side handshake, word and its PC tag
module riscoffee_fetch #(
   parameter int DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_fetch_pc,
   output logic        o_pc_advance,
   input  logic        i_flush,
   output logic        o_imem_req_valid,
   input  logic        i_imem_req_ready,
   output logic [31:0] o_imem_req_addr,
   input  logic        i_imem_resp_valid,
   input  logic [31:0] i_imem_resp_data,
   output logic        o_instr_valid,
   input  logic        i_instr_ready,
   output logic [31:0] o_instr,
   output logic [31:0] o_instr_pc
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = CNT_W - 1;
   localparam int SUM_W = CNT_W + 2;

   typedef enum logic [1:0] {S_WAKE, S_RUN, S_DRAIN} state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_inflight, r_count, r_discard;
   logic [CNT_W-1:0] w_inflight_nxt, w_count_nxt, w_discard_nxt;
   logic [PTR_W-1:0] r_tag_rd, r_tag_wr, r_q_rd, r_q_wr;
   logic [31:0]      r_tag_mem [DEPTH];
   logic [31:0]      r_q_instr [DEPTH];
   logic [31:0]      r_q_pc    [DEPTH];
   logic [SUM_W-1:0] w_occ;
   logic             w_req, w_push_req, w_resp_live, w_resp_drop, w_resp_take, w_pop;

   // Every slot is reserved at request time, so buffered words can never overflow the queue.
   assign w_occ      = SUM_W'(r_inflight) + SUM_W'(r_count) + SUM_W'(r_discard);
   assign w_req      = (r_state != S_WAKE) && !i_flush && (w_occ < SUM_W'(DEPTH));
   assign w_push_req = w_req && i_imem_req_ready;
   // A response with nothing outstanding is a protocol error; it must not move any counter.
   assign w_resp_live = i_imem_resp_valid && ((r_inflight != '0) || (r_discard != '0));
   assign w_resp_drop = w_resp_live && (r_discard != '0);
   assign w_resp_take = w_resp_live && (r_discard == '0) && !i_flush;
   assign w_pop       = o_instr_valid && i_instr_ready;

   assign o_imem_req_valid = w_req;
   assign o_imem_req_addr  = {i_fetch_pc[31:2], 2'b00};
   assign o_pc_advance     = w_push_req;
   assign o_instr_valid    = (r_count != '0) && !i_flush;
   assign o_instr          = r_q_instr[r_q_rd];
   assign o_instr_pc       = r_q_pc[r_q_rd];

   always_comb begin
      w_inflight_nxt = r_inflight;
      w_count_nxt    = r_count;
      w_discard_nxt  = r_discard;
      if (i_flush) begin
         // Everything still owed by memory becomes stale, minus a response that lands this cycle.
         w_inflight_nxt = '0;
         w_count_nxt    = '0;
         w_discard_nxt  = r_discard + r_inflight - CNT_W'(w_resp_live);
      end else begin
         w_inflight_nxt = r_inflight + CNT_W'(w_push_req) - CNT_W'(w_resp_take);
         w_count_nxt    = r_count + CNT_W'(w_resp_take) - CNT_W'(w_pop);
         w_discard_nxt  = r_discard - CNT_W'(w_resp_drop);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_WAKE:  w_state_nxt = S_RUN;
         S_RUN:   if (i_flush && (w_discard_nxt != '0)) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_discard_nxt == '0) w_state_nxt = S_RUN;
         default: w_state_nxt = S_WAKE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_WAKE;
         r_inflight <= '0;
         r_count    <= '0;
         r_discard  <= '0;
         r_tag_rd   <= '0;
         r_tag_wr   <= '0;
         r_q_rd     <= '0;
         r_q_wr     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_tag_mem[i] <= '0;
            r_q_instr[i] <= '0;
            r_q_pc[i]    <= '0;
         end
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_inflight_nxt;
         r_count    <= w_count_nxt;
         r_discard  <= w_discard_nxt;
         if (i_flush) begin
            r_tag_rd <= '0;
            r_tag_wr <= '0;
            r_q_rd   <= '0;
            r_q_wr   <= '0;
         end else begin
            if (w_push_req) begin
               r_tag_mem[r_tag_wr] <= i_fetch_pc;
               r_tag_wr            <= r_tag_wr + PTR_W'(1);
            end
            if (w_resp_take) begin
               r_q_instr[r_q_wr] <= i_imem_resp_data;
               r_q_pc[r_q_wr]    <= r_tag_mem[r_tag_rd];
               r_q_wr            <= r_q_wr + PTR_W'(1);
               r_tag_rd          <= r_tag_rd + PTR_W'(1);
            end
            if (w_pop) begin
               r_q_rd <= r_q_rd + PTR_W'(1);
            end
         end
      end
   end

   a_orphan_resp: assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_imem_resp_valid && (r_inflight == '0) && (r_discard == '0)));
   a_occupancy: assert property (@(posedge i_clk) disable iff (i_rst)
      w_occ <= SUM_W'(DEPTH));
endmodule
